// File: rtl/sal_bank_fsm.sv
// Per-bank DRAM command sequencer: ACT/RD/WR/PRE/REF with per-command timing counters.
// Optional closed-page policy is enabled by defining SAL_BANK_AUTO_PRE_EN.
module sal_bank_fsm #(
  parameter int TW    = 8,
  parameter int ROW_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    t_rcd,
  input  logic [TW-1:0]    t_rp,
  input  logic [TW-1:0]    t_ras,
  input  logic [TW-1:0]    t_rfc,
  input  logic [TW-1:0]    t_rtp,
  input  logic [TW-1:0]    t_wtp,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [ROW_W-1:0] req_row,
  output logic             req_ready,
  input  logic             ref_req,
  output logic             ref_done,
  output logic             cmd_valid,
  output logic [2:0]       cmd_type,
  output logic [ROW_W-1:0] cmd_row,
  input  logic             cmd_ready,
  output logic             row_open,
  output logic [ROW_W-1:0] open_row
);

  typedef enum logic [2:0] {
    CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING
  } state_t;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  localparam logic [TW-1:0] ONE = TW'(1);

  state_t           state, state_nx;
  logic [TW-1:0]    tmr_rcd, tmr_ras, tmr_rp, tmr_rfc, tmr_rtp, tmr_wtp;
  logic             pend;
  logic [2:0]       pend_type;
  logic [ROW_W-1:0] pend_row;
  logic             want_valid;
  logic [2:0]       want_type;
  logic [ROW_W-1:0] want_row;
  logic             acc;
  logic             pre_ok;
  logic             hit;
  logic             close_row;

  // Accept at cycle N must make the dependent command legal at N+max(t,1).
  function automatic logic [TW-1:0] ld(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - ONE;
  endfunction

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= CLOSED;
    else     state <= state_nx;
  end

  // Transitional states hand over one cycle early (timer<=1) so that the
  // follow-on command is offered exactly on the cycle its timer reaches 0.
  always_comb begin
    state_nx = state;
    case (state)
      CLOSED:
        if (acc && cmd_type == C_REF)      state_nx = REFRESHING;
        else if (acc && cmd_type == C_ACT) state_nx = (t_rcd <= ONE) ? OPEN : ACTIVATING;
      ACTIVATING:
        if (tmr_rcd <= ONE) state_nx = OPEN;
      OPEN:
        if (acc && cmd_type == C_PRE) state_nx = (t_rp <= ONE) ? CLOSED : PRECHARGING;
      PRECHARGING:
        if (tmr_rp <= ONE) state_nx = CLOSED;
      REFRESHING:
        if (tmr_rfc == '0) state_nx = CLOSED;
      default: state_nx = CLOSED;
    endcase
  end

  always_comb begin
    want_valid = 1'b0;
    want_type  = C_NOP;
    want_row   = open_row;
    pre_ok     = (tmr_ras == '0) && (tmr_rtp == '0) && (tmr_wtp == '0);
    hit        = (req_row == open_row);
`ifdef SAL_BANK_AUTO_PRE_EN
    close_row  = ref_req || (req_valid && !hit) || !req_valid;
`else
    close_row  = ref_req || (req_valid && !hit);
`endif
    case (state)
      CLOSED:
        if (tmr_rp == '0) begin
          if (ref_req) begin
            want_valid = 1'b1;
            want_type  = C_REF;
          end else if (req_valid) begin
            want_valid = 1'b1;
            want_type  = C_ACT;
            want_row   = req_row;
          end
        end
      OPEN:
        if (close_row) begin
          if (pre_ok) begin
            want_valid = 1'b1;
            want_type  = C_PRE;
          end
        end else if (req_valid) begin
          want_valid = 1'b1;
          want_type  = req_wr ? C_WR : C_RD;
        end
      default: ;
    endcase

    // A command that was offered but not taken is replayed unchanged.
    cmd_valid = !rst && (pend || want_valid);
    cmd_type  = !cmd_valid ? C_NOP : (pend ? pend_type : want_type);
    cmd_row   = pend ? pend_row : want_row;
    acc       = cmd_valid && cmd_ready;
    req_ready = acc && (cmd_type == C_RD || cmd_type == C_WR);
    ref_done  = !rst && (state == REFRESHING) && (tmr_rfc == '0);
    row_open  = !rst && (state == ACTIVATING || state == OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_type <= C_NOP;
      pend_row  <= '0;
      open_row  <= '0;
      tmr_rcd   <= '0;
      tmr_ras   <= '0;
      tmr_rp    <= '0;
      tmr_rfc   <= '0;
      tmr_rtp   <= '0;
      tmr_wtp   <= '0;
    end else begin
      if (acc) begin
        pend <= 1'b0;
      end else if (cmd_valid) begin
        pend      <= 1'b1;
        pend_type <= cmd_type;
        pend_row  <= cmd_row;
      end
      if (acc && cmd_type == C_ACT) open_row <= cmd_row;

      tmr_rcd <= (acc && cmd_type == C_ACT) ? ld(t_rcd) : dec(tmr_rcd);
      tmr_ras <= (acc && cmd_type == C_ACT) ? ld(t_ras) : dec(tmr_ras);
      tmr_rp  <= (acc && cmd_type == C_PRE) ? ld(t_rp)  : dec(tmr_rp);
      tmr_rfc <= (acc && cmd_type == C_REF) ? ld(t_rfc) : dec(tmr_rfc);
      tmr_rtp <= (acc && cmd_type == C_RD)  ? ld(t_rtp) : dec(tmr_rtp);
      tmr_wtp <= (acc && cmd_type == C_WR)  ? ld(t_wtp) : dec(tmr_wtp);
    end
  end

endmodule

// File: tb/tb_sal_bank_fsm.sv
// Bench for sal_bank_fsm: vector table of request scenarios checked through an event
// scoreboard, plus hand-written backpressure and mid-operation reset sequences.
module tb_sal_bank_fsm;
  localparam int TW = 8;
  localparam int RW = 14;

  // event kinds: 1 ACT 2 RD 3 WR 4 PRE 5 REF 6 req_ready 7 ref_done
  typedef struct {
    int k;
    int r;
    int c;
  } ev_t;

  typedef struct {
    int v;
    int k;
    int r;
    int c;
  } tev_t;

  typedef struct {
    int rcd, rp, ras, rfc, rtp, wtp;
    int nreq;
    logic [2:0] wr;
    logic [2:0][RW-1:0] row;
    int ref_at;
    int ncyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [TW-1:0] t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic req_valid = 1'b0, req_wr = 1'b0, ref_req = 1'b0, cmd_ready = 1'b1;
  logic [RW-1:0] req_row = '0;
  logic req_ready, ref_done, cmd_valid, row_open;
  logic [2:0] cmd_type;
  logic [RW-1:0] cmd_row, open_row;

  sal_bank_fsm #(.TW(TW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc), .t_rtp(t_rtp), .t_wtp(t_wtp),
    .req_valid(req_valid), .req_wr(req_wr), .req_row(req_row), .req_ready(req_ready),
    .ref_req(ref_req), .ref_done(ref_done),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_row(cmd_row), .cmd_ready(cmd_ready),
    .row_open(row_open), .open_row(open_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t  exp_q[$];
  tev_t tev[$];
  vec_t vecs[5];
  int checks = 0, errors = 0, base = 0;
  bit mon_en = 0, rdy_seen = 0, done_seen = 0;

  task automatic sb(input int k, input int r);
    ev_t e;
    int rc;
    rc = cyc - base;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_extra: got kind %0d row %0d at cycle %0d, nothing expected", k, r, rc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.r != r || e.c != rc) begin
        errors++;
        $display("FAIL sb_event: got kind %0d row %0d at cycle %0d, expected kind %0d row %0d at cycle %0d",
                 k, r, rc, e.k, e.r, e.c);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (cmd_valid && cmd_ready) sb(int'(cmd_type), int'(cmd_row));
    if (req_ready) begin sb(6, 0); rdy_seen = 1; end
    if (ref_done)  begin sb(7, 0); done_seen = 1; end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic expect_ev(input int k, input int r, input int c);
    exp_q.push_back('{k, r, c});
  endtask

  task automatic add(input int v, input int k, input int r, input int c);
    tev.push_back('{v, k, r, c});
  endtask

  function automatic vec_t mkv(input int rcd, input int rp, input int ras, input int rfc,
                               input int rtp, input int wtp, input int nreq, input logic [2:0] wr,
                               input logic [2:0][RW-1:0] row, input int ref_at, input int ncyc);
    vec_t v;
    v.rcd = rcd; v.rp = rp; v.ras = ras; v.rfc = rfc; v.rtp = rtp; v.wtp = wtp;
    v.nreq = nreq; v.wr = wr; v.row = row; v.ref_at = ref_at; v.ncyc = ncyc;
    return v;
  endfunction

  task automatic set_timing(input vec_t v);
    t_rcd = TW'(v.rcd); t_rp = TW'(v.rp); t_ras = TW'(v.ras);
    t_rfc = TW'(v.rfc); t_rtp = TW'(v.rtp); t_wtp = TW'(v.wtp);
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst = 1; req_valid = 0; ref_req = 0; cmd_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_q.delete();
    rdy_seen = 0; done_seen = 0;
  endtask

  task automatic start_seq();
    @(posedge clk); #1;
    base = cyc; mon_en = 1; rdy_seen = 0; done_seen = 0;
  endtask

  task automatic end_seq();
    @(posedge clk); #1;
    mon_en = 0;
    chk("missing_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int ri;
    v = vecs[vi];
    ri = 0;
    set_timing(v);
    do_reset();
    foreach (tev[i]) if (tev[i].v == vi) expect_ev(tev[i].k, tev[i].r, tev[i].c);
    start_seq();
    for (int c = 0; c < v.ncyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rdy_seen) begin ri++; rdy_seen = 0; end
      if (done_seen) begin ref_req = 0; done_seen = 0; end
      if (c == v.ref_at) ref_req = 1;
      if (ri < v.nreq && ri < 3) begin
        req_valid = 1; req_wr = v.wr[ri]; req_row = v.row[ri];
      end else begin
        req_valid = 0;
      end
    end
    end_seq();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mkv(3, 3, 8, 20, 2, 6, 1, 3'b000, {14'd0, 14'd0, 14'd5}, -1, 30);
    vecs[1] = mkv(3, 3, 8, 20, 2, 6, 2, 3'b001, {14'd0, 14'd9, 14'd5}, -1, 30);
    vecs[2] = mkv(0, 0, 0, 20, 0, 0, 2, 3'b000, {14'd0, 14'd4, 14'd3}, -1, 15);
    vecs[3] = mkv(2, 2, 5, 20, 4, 1, 3, 3'b010, {14'd1, 14'd7, 14'd7}, -1, 25);
    vecs[4] = mkv(3, 3, 8, 20, 2, 6, 2, 3'b000, {14'd0, 14'd5, 14'd5}, 4, 50);

    add(0, 1, 5, 0); add(0, 2, 5, 3); add(0, 6, 0, 3);
    add(1, 1, 5, 0); add(1, 3, 5, 3); add(1, 6, 0, 3); add(1, 4, 5, 9);
    add(1, 1, 9, 12); add(1, 2, 9, 15); add(1, 6, 0, 15);
    add(2, 1, 3, 0); add(2, 2, 3, 1); add(2, 6, 0, 1); add(2, 4, 3, 2);
    add(2, 1, 4, 3); add(2, 2, 4, 4); add(2, 6, 0, 4);
    add(3, 1, 7, 0); add(3, 2, 7, 2); add(3, 6, 0, 2); add(3, 3, 7, 3); add(3, 6, 0, 3);
    add(3, 4, 7, 6); add(3, 1, 1, 8); add(3, 2, 1, 10); add(3, 6, 0, 10);
    add(4, 1, 5, 0); add(4, 2, 5, 3); add(4, 6, 0, 3); add(4, 4, 5, 8); add(4, 5, 5, 11);
    add(4, 7, 0, 31); add(4, 1, 5, 32); add(4, 2, 5, 35); add(4, 6, 0, 35);
`ifdef SAL_BANK_AUTO_PRE_EN
    add(0, 4, 5, 8); add(1, 4, 9, 20); add(2, 4, 4, 5); add(3, 4, 1, 14); add(4, 4, 5, 40);
`endif

    // reset state, with requests held high during reset
    set_timing(vecs[0]);
    rst = 1; req_valid = 1; req_row = 14'd5; ref_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_type", int'(cmd_type), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_ref_done", int'(ref_done), 0);
    chk("rst_row_open", int'(row_open), 0);
    chk("rst_open_row", int'(open_row), 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // ACT held under backpressure, timer starts at accept
    set_timing(vecs[0]);
    do_reset();
    expect_ev(1, 6, 4); expect_ev(2, 6, 7); expect_ev(6, 0, 7);
    start_seq();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rdy_seen) begin req_valid = 0; rdy_seen = 0; end
      else if (c == 0) begin req_valid = 1; req_wr = 0; req_row = 14'd6; end
      cmd_ready = (c >= 4);
      if (c < 4) begin
        @(negedge clk);
        chk("bp_cmd_valid", int'(cmd_valid), 1);
        chk("bp_cmd_type", int'(cmd_type), 1);
        chk("bp_cmd_row", int'(cmd_row), 6);
      end
    end
    end_seq();

    // reset during ACTIVATING
    do_reset();
    expect_ev(1, 5, 0); expect_ev(1, 5, 3); expect_ev(2, 5, 6); expect_ev(6, 0, 6);
    start_seq();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rdy_seen) begin req_valid = 0; rdy_seen = 0; end
      if (c == 0 || c == 3) begin req_valid = 1; req_wr = 0; req_row = 14'd5; end
      if (c == 1) begin rst = 1; req_valid = 0; end
      if (c == 2) begin
        rst = 0;
        @(negedge clk);
        chk("mid_rst_cmd_valid", int'(cmd_valid), 0);
        chk("mid_rst_cmd_type", int'(cmd_type), 0);
        chk("mid_rst_row_open", int'(row_open), 0);
        chk("mid_rst_open_row", int'(open_row), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
      end
    end
    end_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sal_bank_fsm.md
SAL_BANK_FSM -- requirements
Module: sal_bank_fsm

Interface
REQ-001 SHALL have parameter TW, default 8, meaning width of every timing input and internal timer.
REQ-002 SHALL have parameter ROW_W, default 14, meaning row address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp  input  TW each  timing values in cycles, quasi-static.
REQ-006 SHALL have port req_valid  input  1  scheduler holds a read/write request for this bank.
REQ-007 SHALL have port req_wr  input  1  1=write, 0=read.
REQ-008 SHALL have port req_row  input  ROW_W  target row.
REQ-009 SHALL have port req_ready  output  1  one-cycle pulse when the RD/WR for the held request is accepted.
REQ-010 SHALL have port ref_req  input  1  level refresh request.
REQ-011 SHALL have port ref_done  output  1  one-cycle pulse when tRFC after REF has elapsed.
REQ-012 SHALL have port cmd_valid  output  1  command offered.
REQ-013 SHALL have port cmd_type  output  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF.
REQ-014 SHALL have port cmd_row  output  ROW_W  row for ACT, else open row.
REQ-015 SHALL have port cmd_ready  input  1  command accepted when cmd_valid and cmd_ready are high in the same cycle.
REQ-016 SHALL have ports row_open  output  1  and  open_row  output  ROW_W, giving the bank's open-row status.

Function
REQ-017 SHALL implement states CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING.
REQ-018 Timer rule SHALL be: each command accepted at cycle N loads its timer so that the dependent command is first acceptable at N+max(t,1); timers saturate at 0.
REQ-019 In CLOSED with ref_req SHALL offer REF; on accept go to REFRESHING for tRFC, pulse ref_done on the cycle the timer expires, then return to CLOSED.
REQ-020 In CLOSED with req_valid and no ref_req SHALL offer ACT(req_row) once tRP since the last PRE has elapsed; on accept latch open_row and go to ACTIVATING.
REQ-021 ACTIVATING SHALL go to OPEN when tRCD has elapsed.
REQ-022 In OPEN with req_valid, req_row==open_row and no ref_req SHALL offer RD/WR per req_wr; on accept pulse req_ready and restart tRTP (read) or tWTP (write).
REQ-023 In OPEN on a row miss or ref_req SHALL offer PRE only when tRAS since ACT, tRTP since last RD and tWTP since last WR have all elapsed; on accept go to PRECHARGING.
REQ-024 PRECHARGING SHALL go to CLOSED when tRP has elapsed; row_open SHALL be high only in ACTIVATING and OPEN.
REQ-025 ref_req SHALL take priority over req_valid at every decision point; an offered command SHALL stay stable until accepted.
REQ-026 cmd_valid SHALL be low and cmd_type NOP when nothing is offered.

Reset
REQ-027 rst SHALL force CLOSED, clear all timers to 0, and drive cmd_valid, req_ready, ref_done and row_open to 0, open_row to 0.
REQ-028 rst asserted mid-operation SHALL abandon any offered or timed command with no residual pulse.

Configuration
REQ-029 With macro SAL_BANK_AUTO_PRE_EN defined, OPEN with req_valid low and ref_req low SHALL offer PRE as soon as the REQ-023 timing allows (closed page).
REQ-030 Without SAL_BANK_AUTO_PRE_EN, the row SHALL stay open indefinitely when idle (open page).

Verification
REQ-031 Timing 3/3/8/20/2/6 (rcd/rp/ras/rfc/rtp/wtp), cmd_ready=1, read row 5 from reset -> ACT at cycle 0, RD at cycle 3, req_ready at 3.
REQ-032 Row open at 5, ACT at cycle 0, write row 5 at cycle 3, then request row 9 -> PRE no earlier than cycle 9 (tWTP), ACT(9) at 12.
REQ-033 Row open, ref_req raised with req_valid -> PRE, then REF after tRP, ref_done 20 cycles after REF accept, no req_ready meanwhile.
REQ-034 cmd_ready held low 4 cycles while ACT offered -> cmd_type/cmd_row stable, ACT timer starts at the accept cycle.
REQ-035 rst pulsed during ACTIVATING -> next cycle CLOSED, outputs zero, fresh request restarts with ACT.
REQ-036 SAL_BANK_AUTO_PRE_EN defined, single read then req_valid low -> PRE at max(cycle 8, RD+2); undefined -> no PRE.
